universal_shift_register_seq: RTL and testbench
===============================================

// Module: universal_shift_register_seq
// PURPOSE
//   Parametrised successor to the 4-bit load/shift-left/shift-right register.
//   Holds a WIDTH-bit word and performs a multi-bit shift or rotate one bit per clock.
//   Operations are started by a start/busy/done handshake.
//   Serves as the data-path register for serial-link and bit-manipulation toy projects.
// PARAMETERS
//   WIDTH  8  data word width in bits (>=2)
//   AMT_W  4  width of shift amount port; must satisfy 2**AMT_W > WIDTH
// PORTS
//   clk      in   1      rising-edge clock
//   reset    in   1      synchronous, active-high reset
//   ld       in   1      parallel load request (IDLE only)
//   start    in   1      begin shift op (IDLE only, ld=0)
//   mode     in   3      000 SLL, 001 SRL, 010 ROL, 011 ROR, 100 SRA, 101-111 reserved
//   amt      in   AMT_W  number of bit positions to move
//   ser_in   in   1      fill bit for SLL/SRL, sampled at every shift edge
//   d_in     in   WIDTH  parallel load data
//   out      out  WIDTH  register contents
//   ser_out  out  1      last bit shifted or rotated out
//   busy     out  1      high while a shift op is in progress
//   done     out  1      one-cycle pulse when an op completes
// BEHAVIOUR
//   Reset (sync, highest priority, any state):
//     - out=0, ser_out=0, busy=0, done=0, counter=0, state=IDLE.
//     - An op in flight is aborted and produces no done pulse.
//   FSM states: IDLE, SHIFT.
//   IDLE:
//     - ld=1: out<=d_in at the next edge. ld has priority over start.
//     - start=1 & ld=0: latch mode and cnt=min(amt,WIDTH).
//     - Then, if cnt==0 or mode is reserved: done=1 next cycle, out unchanged, stay IDLE.
//     - Otherwise: busy<=1 and go to SHIFT.
//   SHIFT: one step per edge, cnt decrements each step. Step per latched mode:
//     - SLL: out<={out[W-2:0],ser_in}, ser_out<=out[W-1].
//     - SRL: out<={ser_in,out[W-1:1]}, ser_out<=out[0].
//     - ROL: out<={out[W-2:0],out[W-1]}, ser_out<=out[W-1].
//     - ROR: out<={out[0],out[W-1:1]}, ser_out<=out[0].
//     - SRA: out<={out[W-1],out[W-1:1]}, ser_out<=out[0].
//   Timing: start sampled at edge T0; shifts occur at edges T1..Tn (n=cnt).
//     - At Tn: busy<=0, done<=1, return to IDLE.
//     - done clears at Tn+1. Latency from start to done is n+1 cycles.
//   Busy rules: start and ld are ignored while busy=1. mode and amt are not re-sampled.
//   Back-to-back: start asserted in the cycle done=1 is accepted (state is IDLE).
//   Clamp: amt>WIDTH is treated as WIDTH.
//     - ROL/ROR by WIDTH returns the original word.
//     - SLL/SRL by WIDTH returns all fill bits.
//   ser_out holds its value between ops. It is not changed by ld.
// TESTING
//   1. Reset, then ld=1 with d_in=8'hB5 -> out=B5 next cycle; busy=0, done=0.
//   2. From B5, start SLL amt=3 ser_in=0 -> busy for 3 cycles, out=8'hA8,
//      ser_out=1, done pulses once.
//   3. From B5, start ROR amt=4 -> out=8'h5B; done exactly 5 cycles after start edge.
//   4. ld 8'h96, start SRA amt=2 -> out=8'hE5, ser_out=1.
//      A start pulse while busy is ignored.
//   5. SRL amt=5, reset asserted after the 2nd shift -> next edge out=00, busy=0;
//      no done pulse follows.
//   6. amt=0 -> done at T1 with out unchanged.
//      ROL amt=12 on 8'h3C -> clamped to 8: busy 8 cycles, out=3C.

Source files
------------

// File: rtl/universal_shift_register_seq_if.sv
// Bus bundle for the universal shift register: load/start controls, data in,
// and register contents plus busy/done status back to the requester.
interface universal_shift_register_seq_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             ld;
    logic             start;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amt;
    logic             ser_in;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] out;
    logic             ser_out;
    logic             busy;
    logic             done;

    modport master (
        output ld, start, mode, amt, ser_in, d_in,
        input  out, ser_out, busy, done
    );

    modport slave (
        input  ld, start, mode, amt, ser_in, d_in,
        output out, ser_out, busy, done
    );
endinterface

// File: rtl/universal_shift_register_seq.sv
// WIDTH-bit register with parallel load and multi-bit shift/rotate, one bit per clock,
// driven by a start/busy/done handshake.
module universal_shift_register_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    universal_shift_register_seq_if.slave  bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [AMT_W-1:0] WIDTH_CNT = AMT_W'(WIDTH);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] word_reg, word_next;
    logic             ser_out_reg, ser_out_next;
    logic [AMT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       mode_reg, mode_next;
    logic             done_reg, done_next;

    logic [AMT_W-1:0] amt_clamped;
    logic [WIDTH-1:0] step_word;
    logic             step_bit;

    assign amt_clamped = (bus.amt > WIDTH_CNT) ? WIDTH_CNT : bus.amt;

    // State register: control state and datapath share one synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            word_reg    <= '0;
            ser_out_reg <= 1'b0;
            cnt_reg     <= '0;
            mode_reg    <= 3'b000;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            word_reg    <= word_next;
            ser_out_reg <= ser_out_next;
            cnt_reg     <= cnt_next;
            mode_reg    <= mode_next;
            done_reg    <= done_next;
        end
    end

    // Single-bit step for the latched mode; the fill bit is sampled live each edge.
    always_comb begin
        step_word = word_reg;
        step_bit  = ser_out_reg;
        case (mode_reg)
            3'b000: begin
                step_word = {word_reg[WIDTH-2:0], bus.ser_in};
                step_bit  = word_reg[WIDTH-1];
            end
            3'b001: begin
                step_word = {bus.ser_in, word_reg[WIDTH-1:1]};
                step_bit  = word_reg[0];
            end
            3'b010: begin
                step_word = {word_reg[WIDTH-2:0], word_reg[WIDTH-1]};
                step_bit  = word_reg[WIDTH-1];
            end
            3'b011: begin
                step_word = {word_reg[0], word_reg[WIDTH-1:1]};
                step_bit  = word_reg[0];
            end
            3'b100: begin
                step_word = {word_reg[WIDTH-1], word_reg[WIDTH-1:1]};
                step_bit  = word_reg[0];
            end
            default: begin
                step_word = word_reg;
                step_bit  = ser_out_reg;
            end
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        word_next    = word_reg;
        ser_out_next = ser_out_reg;
        cnt_next     = cnt_reg;
        mode_next    = mode_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.ld) begin
                    word_next = bus.d_in;
                end else if (bus.start) begin
                    mode_next = bus.mode;
                    // Zero-length or reserved ops complete immediately without touching the word.
                    if (amt_clamped == '0 || bus.mode > 3'b100) begin
                        cnt_next  = '0;
                        done_next = 1'b1;
                    end else begin
                        cnt_next   = amt_clamped;
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                word_next    = step_word;
                ser_out_next = step_bit;
                cnt_next     = cnt_reg - 1'b1;
                if (cnt_reg == AMT_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.out     = word_reg;
        bus.ser_out = ser_out_reg;
        bus.busy    = (state_reg == SHIFT);
        bus.done    = done_reg;
    end
endmodule

// File: tb/tb_universal_shift_register_seq.sv
// Randomized bench for universal_shift_register_seq, checked against a whole-operation
// arithmetic model of load/shift/rotate results.
module tb_universal_shift_register_seq;
    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    universal_shift_register_seq_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    universal_shift_register_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [WIDTH-1:0] m_word;
    logic             m_so;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Result of a complete op as {ser_out, word}; fills[k] is the ser_in bit at the k-th shift.
    function automatic logic [WIDTH:0] model_op(input logic [2:0] mode, input logic [WIDTH-1:0] w,
                                                input int n, input logic [WIDTH-1:0] fills,
                                                input logic so_in);
        logic [WIDTH-1:0]        r;
        logic [WIDTH-1:0]        fw;
        logic signed [WIDTH-1:0] sw;
        logic                    so;
        if (n == 0 || mode > 3'd4) return {so_in, w};
        fw = '0;
        sw = w;
        r  = w;
        so = so_in;
        case (mode)
            3'd0: begin
                for (int k = 0; k < n; k++) fw[n-1-k] = fills[k];
                r  = (w << n) | fw;
                so = w[WIDTH-n];
            end
            3'd1: begin
                for (int k = 0; k < n; k++) fw[WIDTH-n+k] = fills[k];
                r  = (w >> n) | fw;
                so = w[n-1];
            end
            3'd2: begin
                r  = (w << n) | (w >> (WIDTH - n));
                so = w[WIDTH-n];
            end
            3'd3: begin
                r  = (w >> n) | (w << (WIDTH - n));
                so = w[n-1];
            end
            default: begin
                r  = sw >>> n;
                so = w[n-1];
            end
        endcase
        return {so, r};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.ld    = 1'b0;
        bus.start = 1'b0;
        step();
        reset  = 1'b0;
        m_word = '0;
        m_so   = 1'b0;
        check("rst_out", bus.out, 0);
        check("rst_ser_out", bus.ser_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        $display("reset: out=%h busy=%b done=%b", bus.out, bus.busy, bus.done);
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        bus.ld    = 1'b1;
        bus.start = 1'($urandom);
        bus.mode  = 3'($urandom);
        bus.amt   = AMT_W'($urandom);
        bus.d_in  = v;
        step();
        bus.ld    = 1'b0;
        bus.start = 1'b0;
        m_word    = v;
        check("ld_out", bus.out, m_word);
        check("ld_ser_out", bus.ser_out, m_so);
        check("ld_busy", bus.busy, 0);
        check("ld_done", bus.done, 0);
        $display("load: d_in=%h out=%h", v, bus.out);
    endtask

    task automatic idle(input int cycles);
        bus.ld    = 1'b0;
        bus.start = 1'b0;
        repeat (cycles) begin
            step();
            check("idle_done", bus.done, 0);
            check("idle_busy", bus.busy, 0);
            check("idle_out", bus.out, m_word);
        end
    endtask

    // fill_sel: 0/1 constant fill bit, 2 random fill bit per shift.
    task automatic run_op(input logic [2:0] mode, input logic [AMT_W-1:0] amt, input int fill_sel);
        int               n;
        logic [WIDTH-1:0] fills;
        logic [WIDTH:0]   exp;
        logic [WIDTH-1:0] orig;
        n = (int'(amt) > WIDTH) ? WIDTH : int'(amt);
        if (mode > 3'd4) n = 0;
        fills     = '0;
        orig      = m_word;
        bus.ld    = 1'b0;
        bus.start = 1'b1;
        bus.mode  = mode;
        bus.amt   = amt;
        bus.ser_in = 1'($urandom);
        step();
        bus.start = 1'b0;
        for (int k = 0; k < n; k++) begin
            check("op_busy", bus.busy, 1);
            check("op_done_early", bus.done, 0);
            bus.start  = 1'($urandom);
            bus.ld     = 1'($urandom);
            bus.d_in   = WIDTH'($urandom);
            bus.mode   = 3'($urandom);
            bus.amt    = AMT_W'($urandom);
            fills[k]   = (fill_sel == 2) ? 1'($urandom) : 1'(fill_sel);
            bus.ser_in = fills[k];
            step();
        end
        bus.start = 1'b0;
        bus.ld    = 1'b0;
        exp    = model_op(mode, orig, n, fills, m_so);
        m_word = exp[WIDTH-1:0];
        m_so   = exp[WIDTH];
        check("op_done", bus.done, 1);
        check("op_busy_end", bus.busy, 0);
        check("op_out", bus.out, m_word);
        check("op_ser_out", bus.ser_out, m_so);
        $display("op: mode=%0d amt=%0d from=%h out=%h ser_out=%b", mode, amt, orig, bus.out, bus.ser_out);
    endtask

    initial begin
        reset      = 1'b1;
        bus.ld     = 1'b0;
        bus.start  = 1'b0;
        bus.mode   = 3'd0;
        bus.amt    = '0;
        bus.ser_in = 1'b0;
        bus.d_in   = '0;
        step();
        do_reset();

        do_load(8'hB5);
        run_op(3'd0, 4'd3, 0);
        check("sll3_const", bus.out, 8'hA8);
        check("sll3_so_const", bus.ser_out, 1);
        idle(2);

        do_load(8'hB5);
        run_op(3'd3, 4'd4, 2);
        check("ror4_const", bus.out, 8'h5B);
        idle(1);

        do_load(8'h96);
        run_op(3'd4, 4'd2, 2);
        check("sra2_const", bus.out, 8'hE5);
        check("sra2_so_const", bus.ser_out, 1);
        idle(1);

        // Abort an SRL by 5 after its second shift: no done may follow.
        do_load(8'hC3);
        bus.start  = 1'b1;
        bus.mode   = 3'd1;
        bus.amt    = 4'd5;
        step();
        bus.start  = 1'b0;
        repeat (2) begin
            bus.ser_in = 1'($urandom);
            step();
        end
        reset = 1'b1;
        step();
        reset  = 1'b0;
        m_word = '0;
        m_so   = 1'b0;
        check("abort_out", bus.out, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_ser_out", bus.ser_out, 0);
        $display("abort: out=%h busy=%b", bus.out, bus.busy);
        idle(6);

        do_load(8'h5A);
        run_op(3'd2, 4'd0, 2);
        idle(1);
        run_op(3'd6, 4'd5, 2);
        idle(1);

        do_load(8'h3C);
        run_op(3'd2, 4'd12, 2);
        check("rol12_const", bus.out, 8'h3C);
        idle(1);

        run_op(3'd0, 4'd2, 2);
        run_op(3'd1, 4'd3, 2);
        run_op(3'd3, 4'd15, 2);
        idle(1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) do_load(WIDTH'($urandom));
            run_op(3'($urandom_range(0, 7)), AMT_W'($urandom), 2);
            if ($urandom_range(0, 1) == 0) idle(1);
        end
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
